memmodel: RTL and testbench
===========================

# memmodel

Parametrised, single-clock behavioural memory model with a request/acknowledge handshake and programmable access latency. It generalises the ideal data cache to arbitrary data width, depth and latency, and adds registered read data, an explicit busy indication and defined reset-abort semantics. It sits on the processor data or instruction port in simulation benches and in early FPGA bring-up, ahead of the real cache controller.

## Interface
- DATA_W, 32: data width in bits; must be a multiple of 8.
- ADDR_W, 10: word-address width; depth = 2**ADDR_W words.
- LATENCY, 3: cycles from request acceptance to ack; legal range 1..255.
- ph1  in  1  clock; all state updates on posedge ph1.
- reset_b  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- adr  in  ADDR_W  word address; captured with req.
- wdata  in  DATA_W  write data; captured with req.
- byteen  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]; captured with req.
- rdata  out  DATA_W  registered read data.
- ack  out  1  completion pulse, exactly one cycle per accepted request.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Storage: array of 2**ADDR_W words of DATA_W bits. Contents are not cleared by reset. Every adr value is in range.
- State machine: IDLE, WAIT, ACK.
  - IDLE with req=1: capture we, adr, wdata and byteen; load cnt = LATENCY; go to WAIT.
  - IDLE with req=0: stay in IDLE.
  - WAIT with cnt>1: decrement cnt.
  - WAIT with cnt==1: complete the access; set ack; go to ACK.
  - ACK: clear ack; go to IDLE. req is ignored in this state.
- Completion, write: for each i with captured byteen[i]=1, update byte i of mem[adr]. Bytes with byteen[i]=0 are unchanged. rdata is unchanged. byteen=0 is a legal no-op write that still acks.
- Completion, read: rdata <= mem[adr] (full word; byteen ignored). rdata holds its value until the next read completes.
- req asserted in WAIT or ACK is ignored, not queued. The requester holds req until it sees ack, then drops it or presents a new request.
- cnt is 8 bits wide; LATENCY=0 or LATENCY>255 is a parameter error and is flagged by a simulation-time check.

## Timing
- Reset values: ack=0, busy=0, rdata=0, state=IDLE, cnt=0.
- Request sampled at edge k → ack high in the cycle following edge k+LATENCY.
- The write is visible in the array, and rdata is valid, in that same cycle.
- Back-to-back accesses: earliest next acceptance is edge k+LATENCY+2, giving one access per LATENCY+2 cycles.
- busy rises after edge k and falls after edge k+LATENCY+1.
- Read after write: a read accepted after the write's ack returns the new data.
- Reset asserted mid-access: the access is abandoned immediately; a pending write is never committed; no ack is produced; rdata returns to 0.
- Reset released with req=1: the request is accepted at the first posedge after release.

## Configuration
- MEMMODEL_STALL_EN defined: adds input port stall (1 bit). While stall=1 in WAIT, cnt holds and completion is deferred. Latency becomes LATENCY plus the number of stalled WAIT cycles. stall has no effect in IDLE or ACK.
- MEMMODEL_STALL_EN undefined: no stall port; latency is fixed at LATENCY.

## Test plan
- Reset check: hold reset_b=0 → ack=0, busy=0, rdata=0. Release; req=0 for 10 cycles → no ack.
- Byte-enable write then read, DATA_W=32, LATENCY=3:
  - Write adr=5, wdata=0xAABBCCDD, byteen=4'b1111, then write adr=5, wdata=0x11223344, byteen=4'b0101.
  - Read adr=5 → rdata=0xAA22CC44.
  - Each ack arrives exactly 3 edges after acceptance and is one cycle wide.
- LATENCY=1 with req held high continuously → acks every 3 cycles with no duplicate accept in the ACK cycle.
- Reset abort:
  - Write adr=7, wdata=0x0 (mem[7]=0x12345678 beforehand); pulse reset_b low during WAIT.
  - No ack; a subsequent read of adr=7 returns 0x12345678.
- Ignored request: pulse req for a different adr during WAIT → single ack; only the original access is performed.
- MEMMODEL_STALL_EN, LATENCY=2: stall=1 for 4 WAIT cycles → ack at acceptance+6; without the macro, ack at acceptance+2.

Source files
------------

// File: rtl/memmodel.sv
// memmodel: behavioural single-clock memory with req/ack handshake and programmable access latency.
// Define MEMMODEL_STALL_EN to add a stall input that freezes the latency countdown while in WAIT.
module memmodel #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic                ph1,
    input  logic                reset_b,
`ifdef MEMMODEL_STALL_EN
    input  logic                stall,
`endif
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byteen,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                busy
);
    localparam int NBYTES = DATA_W / 8;
    localparam logic [7:0] LAT_INIT = 8'(LATENCY);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t              state;
    state_t              state_nx;
    logic [7:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NBYTES-1:0]   be_q;
    logic                hold;
    logic                accept;
    logic                complete;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

`ifdef MEMMODEL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign accept   = (state == ST_IDLE) && req;
    assign complete = (state == ST_WAIT) && !hold && (cnt == 8'd1);

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req)      state_nx = ST_WAIT;
            ST_WAIT: if (complete) state_nx = ST_ACK;
            ST_ACK:                state_nx = ST_IDLE;
            default:               state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Reset drops any captured request, so an abandoned write can never reach the array.
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            cnt     <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            ack <= complete;
            if (accept) begin
                cnt     <= LAT_INIT;
                we_q    <= we;
                adr_q   <= adr;
                wdata_q <= wdata;
                be_q    <= byteen;
            end else if ((state == ST_WAIT) && !hold) begin
                cnt <= cnt - 8'd1;
            end
            if (complete && !we_q) begin
                rdata <= mem[adr_q];
            end
        end
    end

    always_ff @(posedge ph1) begin
        if (complete && we_q) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (be_q[i]) begin
                    mem[adr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    latency_range_a: assert property (@(posedge ph1) (LATENCY >= 1) && (LATENCY <= 255));
    data_width_a:    assert property (@(posedge ph1) (DATA_W % 8) == 0);

endmodule

// File: tb/tb_memmodel.sv
// Self-checking bench for memmodel: transaction-level reference model plus directed vectors.
module tb_memmodel;
    localparam int LAT = 3;

    logic        ph1 = 1'b0;
    logic        reset_b = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  adr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byteen = '0;
    logic        stall = 1'b0;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;

    logic        req1 = 1'b0;
    logic        we1 = 1'b0;
    logic [3:0]  adr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [3:0]  byteen1 = '0;
    logic        stall1 = 1'b0;
    logic [31:0] rdata1;
    logic        ack1;
    logic        busy1;

    int n_pass = 0;
    int n_total = 0;
    int n_ack = 0;

    memmodel #(.DATA_W(32), .ADDR_W(10), .LATENCY(LAT)) u_dut (
        .ph1(ph1), .reset_b(reset_b),
`ifdef MEMMODEL_STALL_EN
        .stall(stall),
`endif
        .req(req), .we(we), .adr(adr), .wdata(wdata), .byteen(byteen),
        .rdata(rdata), .ack(ack), .busy(busy)
    );

    memmodel #(.DATA_W(32), .ADDR_W(4), .LATENCY(1)) u_l1 (
        .ph1(ph1), .reset_b(reset_b),
`ifdef MEMMODEL_STALL_EN
        .stall(stall1),
`endif
        .req(req1), .we(we1), .adr(adr1), .wdata(wdata1), .byteen(byteen1),
        .rdata(rdata1), .ack(ack1), .busy(busy1)
    );

    always #5 ph1 = ~ph1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an access accepted at edge number A completes at edge D (A+LAT plus stalled
    // WAIT edges); busy covers edges A..D, ack follows edge D, next acceptance no earlier than D+2.
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_rdata = '0;
    bit          m_active = 0;
    int          edge_n = 0;
    int          m_acc = 0;
    int          m_done = 0;
    int          m_free = 0;
    logic        m_we;
    logic [9:0]  m_adr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    always @(negedge reset_b) begin
        m_active = 0;
        m_rdata  = '0;
        m_free   = 0;
    end

    always @(posedge ph1) begin
        if (reset_b) begin
            edge_n++;
            if (m_active && edge_n > m_acc && edge_n <= m_done && stall) begin
                m_done++;
            end else if (m_active && edge_n == m_done) begin
                if (m_we) m_mem[m_adr] = (m_mem[m_adr] & ~be_mask(m_be)) | (m_wd & be_mask(m_be));
                else      m_rdata = m_mem[m_adr];
            end
            if (req && edge_n >= m_free) begin
                m_active = 1;
                m_acc    = edge_n;
                m_done   = edge_n + LAT;
                m_we     = we;
                m_adr    = adr;
                m_wd     = wdata;
                m_be     = byteen;
            end
            if (m_active) m_free = m_done + 2;
        end
    end

    always @(negedge ph1) begin
        chk("ack",   {31'd0, ack},  {31'd0, m_active && edge_n == m_done});
        chk("busy",  {31'd0, busy}, {31'd0, m_active && edge_n >= m_acc && edge_n <= m_done});
        chk("rdata", rdata, m_rdata);
    end

    always @(posedge ph1) begin
        #2;
        if (ack) n_ack++;
    end

    task automatic start(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge ph1);
        req = 1'b1; we = w; adr = a; wdata = d; byteen = be;
        @(posedge ph1);
    endtask

    task automatic wait_ack(input int lat0, output int lat);
        lat = lat0;
        while (1) begin
            @(posedge ph1);
            lat++;
            #1;
            if (ack) break;
            if (lat > 200) begin
                chk("ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge ph1);
        req = 1'b0;
    endtask

    task automatic access(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat);
        start(w, a, d, be);
        wait_ack(0, lat);
    endtask

    int lat;
    int acks0;
    logic [11:0] pat_ack;
    logic [11:0] pat_busy;

    initial begin
        #1 reset_b = 1'b0;
        repeat (3) @(negedge ph1);
        chk("rst_ack",   {31'd0, ack},  32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        #2 reset_b = 1'b1;
        repeat (10) @(negedge ph1);
        chk("idle_no_ack", n_ack, 32'd0);

        access(1'b1, 10'd5, 32'hAABBCCDD, 4'b1111, lat);
        chk("wr_latency", lat, 32'd3);
        access(1'b1, 10'd5, 32'h11223344, 4'b0101, lat);
        chk("wr_be_latency", lat, 32'd3);
        access(1'b0, 10'd5, 32'h0, 4'b0000, lat);
        chk("rd_latency", lat, 32'd3);
        chk("rd_be_merge", rdata, 32'hAA22CC44);
        chk("model_be_merge", m_mem[5], 32'hAA22CC44);

        access(1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000, lat);
        chk("noop_wr_rdata_held", rdata, 32'hAA22CC44);
        access(1'b0, 10'd5, 32'h0, 4'b1111, lat);
        chk("noop_wr_unchanged", rdata, 32'hAA22CC44);

        // Reset abort: write of 0 to adr 7 is abandoned; release with a read already requested.
        access(1'b1, 10'd7, 32'h12345678, 4'b1111, lat);
        acks0 = n_ack;
        start(1'b1, 10'd7, 32'h0, 4'b1111);
        @(negedge ph1);
        #2 reset_b = 1'b0; req = 1'b0;
        @(negedge ph1);
        chk("abort_ack",   {31'd0, ack},  32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        #2 reset_b = 1'b1; req = 1'b1; we = 1'b0; adr = 10'd7; byteen = 4'b0000;
        @(posedge ph1);
        #1 chk("abort_busy_release", {31'd0, busy}, 32'd1);
        chk("abort_no_ack", n_ack, acks0);
        wait_ack(0, lat);
        chk("abort_rd_latency", lat, 32'd3);
        chk("abort_not_committed", rdata, 32'h12345678);

        // Request presented for another address while WAIT is in progress must be ignored.
        access(1'b1, 10'd10, 32'h0BADF00D, 4'b1111, lat);
        acks0 = n_ack;
        start(1'b1, 10'd9, 32'hCAFEBABE, 4'b1111);
        @(negedge ph1);
        adr = 10'd10; wdata = 32'hDEADBEEF;
        wait_ack(0, lat);
        @(negedge ph1);
        chk("ignored_single_ack", n_ack, acks0 + 1);
        access(1'b0, 10'd10, 32'h0, 4'b1111, lat);
        chk("ignored_not_done", rdata, 32'h0BADF00D);
        access(1'b0, 10'd9, 32'h0, 4'b1111, lat);
        chk("original_done", rdata, 32'hCAFEBABE);

`ifdef MEMMODEL_STALL_EN
        start(1'b0, 10'd5, 32'h0, 4'b1111);
        @(negedge ph1);
        stall = 1'b1;
        repeat (4) @(negedge ph1);
        stall = 1'b0;
        wait_ack(4, lat);
        chk("stall_latency", lat, 32'd7);
        chk("stall_rdata", rdata, 32'hAA22CC44);
`endif

        // LATENCY=1 instance with req held high: acks after edges 1,4,7,10.
        @(negedge ph1);
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge ph1);
            #1;
            pat_ack[i]  = ack1;
            pat_busy[i] = busy1;
        end
        @(negedge ph1);
        req1 = 1'b0;
        chk("l1_ack_pattern",  {20'd0, pat_ack},  32'h492);
        chk("l1_busy_pattern", {20'd0, pat_busy}, 32'h6DB);

        repeat (3) @(negedge ph1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
